// File: rtl/uart_host_sequencer_if.sv
// uart_host_sequencer_if: host-side handshake bundle of the UART host sequencer.
interface uart_host_sequencer_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       wr_drop;
    logic       rd_req;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_empty;
    logic       clr_req;
    logic       clr_done;
    logic [1:0] rate_sel;
    logic       busy;

    modport master (
        output wr_valid, wr_data, rd_req, clr_req, rate_sel,
        input  wr_ready, wr_drop, rd_valid, rd_data, rd_empty, clr_done, busy
    );

    modport slave (
        input  wr_valid, wr_data, rd_req, clr_req, rate_sel,
        output wr_ready, wr_drop, rd_valid, rd_data, rd_empty, clr_done, busy
    );
endinterface

// File: rtl/uart_host_sequencer.sv
// uart_host_sequencer: turns host write/read/clear requests into the UART wrapper's
// pulse-then-idle control[3:2] protocol; define UART_SEQ_WR_FIFO_EN for a write skid FIFO.
module uart_host_sequencer #(
    parameter int ACT_CYCLES = 1,
    parameter int GAP_CYCLES = 2,
    parameter int WR_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 nReset,
    uart_host_sequencer_if.slave host,
    output logic [3:0]           control,
    output logic [7:0]           tx_data,
    input  logic [7:0]           rx_data
);
    localparam int MAX_CYC = ACT_CYCLES > GAP_CYCLES ? ACT_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(MAX_CYC + 1);
    localparam logic [1:0] CODE_WR = 2'b01, CODE_RD = 2'b10, CODE_CLR = 2'b11;

    typedef enum logic [2:0] {IDLE, CMD, RGAP, CAPT, GAP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    code, code_nx, rate;
    logic          last, take_wr, wq_valid, drop;
    logic [7:0]    wq_data, rd_data;
    logic          rd_valid, rd_empty, wr_drop;

    assign last    = cnt == '0;
    assign take_wr = state == IDLE && !host.clr_req && !host.rd_req && wq_valid;

`ifdef UART_SEQ_WR_FIFO_EN
    localparam int AW = $clog2(WR_DEPTH);

    logic [7:0]  mem [WR_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        full, push, flush;

    assign full          = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
    assign host.wr_ready = nReset && !full;
    assign push          = host.wr_valid && host.wr_ready && host.wr_data != 8'h00;
    assign drop          = host.wr_valid && host.wr_ready && host.wr_data == 8'h00;
    assign flush         = state == IDLE && host.clr_req;
    assign wq_valid      = wptr != rptr;
    assign wq_data       = mem[rptr[AW-1:0]];

    // skid FIFO pointers; a clear discards queued bytes but keeps one pushed on the same edge
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + {{AW{1'b0}}, push};
            rptr <= flush ? wptr : rptr + {{AW{1'b0}}, take_wr};
        end
    end

    // skid FIFO storage
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= host.wr_data;
    end
`else
    logic unused_depth;

    assign unused_depth  = ^WR_DEPTH;
    assign host.wr_ready = nReset && state == IDLE && !host.clr_req && !host.rd_req;
    assign wq_valid      = host.wr_valid && host.wr_data != 8'h00;
    assign wq_data       = host.wr_data;
    assign drop          = host.wr_valid && host.wr_ready && host.wr_data == 8'h00;
`endif

    // state, phase counter and latched command code
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
            cnt   <= '0;
            code  <= 2'b00;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            code  <= code_nx;
        end
    end

    // sequencing: arbitrate in IDLE, then walk code, read capture window and idle gap
    always_comb begin
        state_nx = state;
        cnt_nx   = last ? '0 : cnt - CW'(1);
        code_nx  = code;
        case (state)
            IDLE: begin
                if (host.clr_req || host.rd_req || wq_valid) begin
                    state_nx = CMD;
                    cnt_nx   = CW'(ACT_CYCLES - 1);
                    code_nx  = host.clr_req ? CODE_CLR : host.rd_req ? CODE_RD : CODE_WR;
                end
            end
            CMD: begin
                if (last) begin
                    state_nx = code == CODE_RD ? RGAP : GAP;
                    cnt_nx   = code == CODE_RD ? CW'(1) : CW'(GAP_CYCLES - 1);
                end
            end
            RGAP: begin
                if (last) begin
                    state_nx = CAPT;
                    cnt_nx   = '0;
                end
            end
            CAPT: begin
                state_nx = GAP;
                cnt_nx   = CW'(GAP_CYCLES - 1);
            end
            GAP: begin
                if (last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // wrapper-facing data, rate forwarding and host result pulses
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rate     <= 2'b00;
            tx_data  <= 8'h00;
            rd_data  <= 8'h00;
            rd_empty <= 1'b0;
            rd_valid <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            rate     <= host.rate_sel;
            tx_data  <= take_wr ? wq_data : state_nx == IDLE ? 8'h00 : tx_data;
            rd_valid <= state == CAPT;
            wr_drop  <= drop;
            if (state == CAPT) begin
                rd_data  <= rx_data;
                rd_empty <= rx_data == 8'h00;
            end
        end
    end

    assign control       = {state == CMD ? code : 2'b00, rate};
    assign host.busy     = state != IDLE;
    assign host.clr_done = state == GAP && last && code == CODE_CLR;
    assign host.rd_valid = rd_valid;
    assign host.rd_data  = rd_data;
    assign host.rd_empty = rd_empty;
    assign host.wr_drop  = wr_drop;
endmodule

// File: tb/tb_uart_host_sequencer.sv
// tb_uart_host_sequencer: directed and random host traffic against a command-level model.
module tb_uart_host_sequencer;
    localparam int ACT = 1;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic [3:0] control;
    logic [7:0] tx_data;
    logic [7:0] rx_data;

    uart_host_sequencer_if host();

    uart_host_sequencer #(.ACT_CYCLES(ACT), .GAP_CYCLES(GAP), .WR_DEPTH(4)) dut (
        .clk(clk), .nReset(nReset), .host(host),
        .control(control), .tx_data(tx_data), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // command-level model: kind 0 write, 1 read, 2 clear; off = cycle index within command
    bit         in_seq;
    int         kind;
    int         off;
    logic [7:0] byte_q;
    logic [7:0] exp_rd;
    bit         exp_drop;
    bit         wr_acc;
    logic [1:0] exp_rate;

    // wrapper model
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [1:0] prev_code;
    int         rcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int seq_len(input int k);
        return ACT + GAP + (k == 1 ? 3 : 0);
    endfunction

    function automatic logic [7:0] garbage();
        return 8'($urandom_range(1, 255));
    endfunction

    task automatic reset_model();
        in_seq = 0; kind = 0; off = 0; byte_q = 0; exp_rd = 0;
        exp_drop = 0; wr_acc = 0; exp_rate = 0;
        rxq.delete(); txq.delete(); prev_code = 0; rcnt = 0; rx_data = 0;
        host.wr_valid = 0; host.wr_data = 0; host.rd_req = 0; host.clr_req = 0; host.rate_sel = 0;
    endtask

    task automatic start(input int k, input logic [7:0] b);
        in_seq = 1; off = 0; kind = k;
        byte_q = k == 0 ? b : 8'h00;
        if (k == 1) exp_rd = rxq.size() > 0 ? rxq[0] : 8'h00;
    endtask

    task automatic model_edge();
        exp_drop = 0;
        wr_acc = 0;
        exp_rate = host.rate_sel;
        if (in_seq) begin
            off++;
            if (off == seq_len(kind)) in_seq = 0;
        end else if (host.clr_req) start(2, 0);
        else if (host.rd_req) start(1, 0);
        else if (host.wr_valid) begin
            wr_acc = 1;
            if (host.wr_data == 8'h00) exp_drop = 1;
            else start(0, host.wr_data);
        end
    endtask

    task automatic check_outputs();
        logic [1:0] code;
        bit rdv;
        code = !in_seq || off >= ACT ? 2'b00 : kind == 0 ? 2'b01 : kind == 1 ? 2'b10 : 2'b11;
        rdv = in_seq && kind == 1 && off == ACT + 3;
        check("code", control[3:2], code);
        check("rate", control[1:0], exp_rate);
        check("tx_data", tx_data, in_seq ? byte_q : 8'h00);
        check("busy", host.busy, in_seq);
        check("rd_valid", host.rd_valid, rdv);
        if (rdv) begin
            check("rd_data", host.rd_data, exp_rd);
            check("rd_empty", host.rd_empty, exp_rd == 0);
        end
        check("clr_done", host.clr_done, in_seq && kind == 2 && off == seq_len(2) - 1);
        check("wr_drop", host.wr_drop, exp_drop);
    endtask

    // wrapper acts when the code returns to 00; rx byte is valid for one cycle only
    task automatic wrapper_step();
        if (prev_code == 2'b01 && control[3:2] == 2'b00) txq.push_back(tx_data);
        if (prev_code == 2'b11 && control[3:2] == 2'b00) begin
            txq.delete();
            rxq.delete();
        end
        if (control[3:2] == 2'b10) begin
            rcnt = 3;
            rx_data = garbage();
        end else if (rcnt > 0) begin
            rcnt--;
            rx_data = rcnt == 0 ? (rxq.size() > 0 ? rxq.pop_front() : 8'h00) : garbage();
        end else rx_data = garbage();
        prev_code = control[3:2];
    endtask

    task automatic host_step();
        if (wr_acc) host.wr_valid = 0;
        if (in_seq && kind == 1 && off == ACT + 3) host.rd_req = 0;
        if (in_seq && kind == 2 && off == seq_len(2) - 1) host.clr_req = 0;
    endtask

    task automatic cycle();
        #1 check("wr_ready", host.wr_ready, nReset && !in_seq && !host.clr_req && !host.rd_req);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        wrapper_step();
        host_step();
    endtask

    initial begin
        int lat;
        int dones;
        logic [1:0] codes[$];

        // reset with a write pending
        reset_model();
        host.wr_valid = 1; host.wr_data = 8'h41; host.rate_sel = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check("rst_control", control, 4'h0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_wr_ready", host.wr_ready, 1'b0);
        check("rst_busy", host.busy, 1'b0);
        reset_model();
        #1 nReset = 1;

        // single write
        host.wr_valid = 1; host.wr_data = 8'h41;
        repeat (5) cycle();
        check("wr_txq_size", txq.size(), 1);
        check("wr_txq_byte", txq.pop_front(), 8'h41);

        // read a held byte, then read an empty FIFO
        rxq.push_back(8'h5A);
        host.rd_req = 1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            if (host.rd_valid) lat = i;
        end
        check("rd_latency", lat, 5);
        check("rd_byte", host.rd_data, 8'h5A);
        host.rd_req = 1;
        repeat (8) cycle();
        check("rd_empty_data", host.rd_data, 8'h00);
        check("rd_empty_flag", host.rd_empty, 1'b1);

        // clear, read and write requested together
        rxq.push_back(8'h77);
        txq.delete();
        host.clr_req = 1; host.rd_req = 1; host.wr_valid = 1; host.wr_data = 8'h22;
        dones = 0;
        for (int i = 0; i < 18; i++) begin
            cycle();
            if (control[3:2] != 2'b00) codes.push_back(control[3:2]);
            if (host.clr_done) dones++;
        end
        check("arb_count", codes.size(), 3);
        check("arb_first", codes[0], 2'b11);
        check("arb_second", codes[1], 2'b10);
        check("arb_third", codes[2], 2'b01);
        check("arb_clr_done", dones, 1);
        check("arb_txq", txq.size(), 1);

        // zero byte and rate select
        txq.delete();
        host.wr_valid = 1; host.wr_data = 8'h00; host.rate_sel = 2'b11;
        cycle();
        check("drop_pulse", host.wr_drop, 1'b1);
        check("rate_fwd", control[1:0], 2'b11);
        repeat (3) cycle();
        check("drop_txq", txq.size(), 0);

        // reset in the middle of a write command
        host.rate_sel = 2'b00;
        host.wr_valid = 1; host.wr_data = 8'h33;
        cycle();
        #2 nReset = 0;
        #1;
        check("arst_control", control, 4'h0);
        check("arst_tx_data", tx_data, 8'h00);
        check("arst_busy", host.busy, 1'b0);
        reset_model();
        repeat (2) @(posedge clk);
        #2 nReset = 1;
        repeat (5) cycle();
        check("arst_txq", txq.size(), 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            host.rate_sel = 2'($urandom);
            if (!host.wr_valid && $urandom_range(0, 3) == 0) begin
                host.wr_valid = 1;
                host.wr_data = $urandom_range(0, 4) == 0 ? 8'h00 : 8'($urandom);
            end
            if (!host.rd_req && $urandom_range(0, 9) == 0) host.rd_req = 1;
            if (!host.clr_req && $urandom_range(0, 39) == 0) host.clr_req = 1;
            if (!in_seq && $urandom_range(0, 3) == 0) rxq.push_back(garbage());
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
